// File: rtl/cart_mem_ctrl.sv
// cart_mem_ctrl
// Shares one external 16-bit word memory between the cartridge bus and a ROM
// loader. Each rising cartridge strobe becomes one memory transaction. Read
// data, the data-enable and the dtack acknowledge go back to the board. While
// ld_active is high the loader owns the memory and cartridge edges are dropped.
//
// Ports
//   MCLK, SRES            : clock, asynchronous active-low reset
//   cart_address/cs/oe/lwr/uwr/data_wr : cartridge request side
//   cart_data, cart_data_en, ext_dtack : cartridge response side
//   ld_active, ld_valid, ld_ready, ld_addr, ld_data : loader word-write port
//   mem_req/ack/we/be/addr/wdata/rdata : external memory port (req held to ack)
//
// Optional feature: define CART_PREFETCH_EN to add a one-word read-ahead
// buffer. After each cartridge read of A from memory, A+1 is fetched into it.
// Without the macro there is no buffer and no PF_WAIT state.
module cart_mem_ctrl #(
    parameter int ADDR_W = 23
) (
    input  logic              MCLK,
    input  logic              SRES,
    input  logic [ADDR_W-1:0] cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    input  logic              cart_lwr,
    input  logic              cart_uwr,
    input  logic [15:0]       cart_data_wr,
    output logic [15:0]       cart_data,
    output logic              cart_data_en,
    output logic              ext_dtack,
    input  logic              ld_active,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_LD_WAIT = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
`ifdef CART_PREFETCH_EN
    localparam logic [2:0] S_PF_WAIT = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    logic              r_rd_s, r_rd_d, r_wr_s, r_wr_d, r_lwr_s, r_uwr_s, r_live;
    logic [ADDR_W-1:0] r_addr_s;
    logic [15:0]       r_wdata_s;
    logic [2:0]        r_state;
    logic              r_hold_rd, r_lost;
    logic              r_mem_we;
    logic [1:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata, r_cart_data;

    logic              w_rd_edge, w_wr_edge, w_ld_go, w_rd_req;
    logic [2:0]        w_go, w_eff, w_next;
    logic              w_go_we;
    logic [1:0]        w_go_be;
    logic [ADDR_W-1:0] w_go_addr;
    logic [15:0]       w_go_wdata;
    logic              w_wait, w_ack, w_cur_strobe, w_hold_strobe;

    // All cartridge inputs are registered together so an access is judged on
    // one consistent snapshot of strobes, address and write data.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            r_rd_s    <= 1'b0;
            r_rd_d    <= 1'b0;
            r_wr_s    <= 1'b0;
            r_wr_d    <= 1'b0;
            r_lwr_s   <= 1'b0;
            r_uwr_s   <= 1'b0;
            r_addr_s  <= '0;
            r_wdata_s <= '0;
            r_live    <= 1'b0;
        end else begin
            r_rd_s    <= cart_cs & cart_oe;
            r_rd_d    <= r_rd_s;
            r_wr_s    <= cart_cs & (cart_lwr | cart_uwr);
            r_wr_d    <= r_wr_s;
            r_lwr_s   <= cart_lwr;
            r_uwr_s   <= cart_uwr;
            r_addr_s  <= cart_address;
            r_wdata_s <= cart_data_wr;
            r_live    <= 1'b1;
        end
    end

    // r_live keeps a loader request from reaching mem_req while in reset.
    assign w_rd_edge = r_rd_s & ~r_rd_d & ~ld_active;
    assign w_wr_edge = r_wr_s & ~r_wr_d & ~ld_active;
    assign w_ld_go   = r_live & ld_active & ld_valid;

`ifdef CART_PREFETCH_EN
    logic              r_pf_valid, r_pf_pend, r_rd_defer;
    logic [ADDR_W-1:0] r_pf_addr, r_pf_next;
    logic [15:0]       r_pf_data;
    logic              w_pf_hit;

    // A read that arrived while a prefetch was in flight is retried from IDLE
    // as long as its strobe is still held.
    assign w_rd_req = ~ld_active & ((r_rd_s & ~r_rd_d) | (r_rd_defer & r_rd_s));
    assign w_pf_hit = r_pf_valid & (r_pf_addr == r_addr_s);
`else
    assign w_rd_req = w_rd_edge;
`endif

    // Decision taken in IDLE. The chosen transaction drives the memory
    // fields combinationally in the same cycle so that mem_req can rise one
    // cycle after the strobe; the fields are then latched for the wait states.
    always_comb begin
        w_go       = S_IDLE;
        w_go_addr  = r_mem_addr;
        w_go_we    = r_mem_we;
        w_go_be    = r_mem_be;
        w_go_wdata = r_mem_wdata;
        if (w_ld_go) begin
            w_go       = S_LD_WAIT;
            w_go_addr  = ld_addr;
            w_go_we    = 1'b1;
            w_go_be    = 2'b11;
            w_go_wdata = ld_data;
        end else if (w_rd_req) begin
            w_go_addr = r_addr_s;
            w_go_we   = 1'b0;
            w_go_be   = 2'b11;
`ifdef CART_PREFETCH_EN
            w_go      = w_pf_hit ? S_HOLD : S_RD_WAIT;
`else
            w_go      = S_RD_WAIT;
`endif
        end else if (w_wr_edge) begin
            w_go       = S_WR_WAIT;
            w_go_addr  = r_addr_s;
            w_go_we    = 1'b1;
            w_go_be    = {r_uwr_s, r_lwr_s};
            w_go_wdata = r_wdata_s;
`ifdef CART_PREFETCH_EN
        end else if (r_pf_pend) begin
            w_go      = S_PF_WAIT;
            w_go_addr = r_pf_next;
            w_go_we   = 1'b0;
            w_go_be   = 2'b11;
`endif
        end
    end

    // w_eff is the state the memory port is really in this cycle; from IDLE
    // it is the state being entered, which lets a zero-wait ack complete in
    // the very cycle the request was raised.
    assign w_eff  = (r_state == S_IDLE) ? w_go : r_state;
    assign w_wait = (w_eff == S_RD_WAIT) || (w_eff == S_WR_WAIT) || (w_eff == S_LD_WAIT)
`ifdef CART_PREFETCH_EN
                    || (w_eff == S_PF_WAIT)
`endif
                    ;
    assign w_ack         = mem_ack & w_wait;
    assign w_cur_strobe  = (w_eff == S_RD_WAIT) ? r_rd_s : r_wr_s;
    assign w_hold_strobe = r_hold_rd ? r_rd_s : r_wr_s;

    // A cartridge access whose strobe has been let go is finished silently.
    always_comb begin
        w_next = w_eff;
        case (w_eff)
            S_RD_WAIT, S_WR_WAIT: if (w_ack) w_next = (r_lost | ~w_cur_strobe) ? S_IDLE : S_HOLD;
            S_LD_WAIT:            if (w_ack) w_next = S_IDLE;
`ifdef CART_PREFETCH_EN
            S_PF_WAIT:            if (w_ack) w_next = S_IDLE;
`endif
            S_HOLD:               if (r_state == S_HOLD && !w_hold_strobe) w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    // Sequencer state, latched memory fields and the cartridge read buffer.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            r_state     <= S_IDLE;
            r_hold_rd   <= 1'b0;
            r_lost      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cart_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_mem_we    <= w_go_we;
                r_mem_be    <= w_go_be;
                r_mem_addr  <= w_go_addr;
                r_mem_wdata <= w_go_wdata;
                r_lost      <= 1'b0;
                if (w_go != S_IDLE) r_hold_rd <= (w_go == S_RD_WAIT) || (w_go == S_HOLD);
            end else if ((r_state == S_RD_WAIT || r_state == S_WR_WAIT) && !w_cur_strobe) begin
                r_lost <= 1'b1;
            end
            if (w_ack && w_eff == S_RD_WAIT) r_cart_data <= mem_rdata;
`ifdef CART_PREFETCH_EN
            if (r_state == S_IDLE && w_go == S_HOLD) r_cart_data <= r_pf_data;
`endif
        end
    end

`ifdef CART_PREFETCH_EN
    // Read-ahead buffer. Any loader activity or a cartridge write to the
    // buffered word makes the copy stale.
    always_ff @(posedge MCLK or negedge SRES) begin
        if (!SRES) begin
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b0;
            r_rd_defer <= 1'b0;
            r_pf_addr  <= '0;
            r_pf_next  <= '0;
            r_pf_data  <= '0;
        end else begin
            if (r_state == S_IDLE) r_rd_defer <= 1'b0;
            else if (r_state == S_PF_WAIT && w_rd_edge) r_rd_defer <= 1'b1;
            if (w_ack && w_eff == S_RD_WAIT) begin
                r_pf_pend <= 1'b1;
                r_pf_next <= mem_addr + ADDR_ONE;
            end
            if (w_ack && w_eff == S_PF_WAIT) begin
                r_pf_pend  <= 1'b0;
                r_pf_valid <= 1'b1;
                r_pf_addr  <= mem_addr;
                r_pf_data  <= mem_rdata;
            end
            if (r_state == S_IDLE && w_go == S_WR_WAIT && r_addr_s == r_pf_addr) r_pf_valid <= 1'b0;
            if (ld_active) begin
                r_pf_valid <= 1'b0;
                r_pf_pend  <= 1'b0;
            end
        end
    end
`endif

    assign mem_req      = w_wait;
    assign mem_we       = (r_state == S_IDLE) ? w_go_we    : r_mem_we;
    assign mem_be       = (r_state == S_IDLE) ? w_go_be    : r_mem_be;
    assign mem_addr     = (r_state == S_IDLE) ? w_go_addr  : r_mem_addr;
    assign mem_wdata    = (r_state == S_IDLE) ? w_go_wdata : r_mem_wdata;
    assign ld_ready     = w_ack & (w_eff == S_LD_WAIT);
    assign ext_dtack    = (r_state == S_HOLD) & w_hold_strobe;
    assign cart_data_en = ext_dtack & r_hold_rd;
    assign cart_data    = r_cart_data;

endmodule

// File: tb/tb_cart_mem_ctrl.sv
// tb_cart_mem_ctrl
// Directed bench for cart_mem_ctrl: loader writes, delayed and zero-wait reads,
// byte write, early strobe release, reset during a read and, when built with
// CART_PREFETCH_EN, the read-ahead buffer. A behavioural memory with a
// programmable ack delay answers mem_req and logs every completed transaction.
module tb_cart_mem_ctrl;
    localparam int ADDR_W = 23;

    logic              MCLK = 1'b0;
    logic              SRES = 1'b0;
    logic [ADDR_W-1:0] cart_address = '0;
    logic              cart_cs = 1'b0, cart_oe = 1'b0, cart_lwr = 1'b0, cart_uwr = 1'b0;
    logic [15:0]       cart_data_wr = '0;
    logic [15:0]       cart_data;
    logic              cart_data_en, ext_dtack;
    logic              ld_active = 1'b0, ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [15:0]       ld_data = '0;
    logic              mem_req, mem_we;
    logic              mem_ack = 1'b0;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [1:0]        be;
        logic [15:0]       wdata;
    } txn_t;

    txn_t        txnLog[$];
    txn_t        firstFields;
    logic [15:0] store [int];
    int          memDelay = 0, waitCnt = 0, stableErr = 0, ldReadyCount = 0;
    int          checkCount = 0, passCount = 0;

    always #5 MCLK = ~MCLK;

    cart_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .MCLK(MCLK), .SRES(SRES),
        .cart_address(cart_address), .cart_cs(cart_cs), .cart_oe(cart_oe),
        .cart_lwr(cart_lwr), .cart_uwr(cart_uwr), .cart_data_wr(cart_data_wr),
        .cart_data(cart_data), .cart_data_en(cart_data_en), .ext_dtack(ext_dtack),
        .ld_active(ld_active), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] readWord(input logic [ADDR_W-1:0] a);
        return store.exists(int'(a)) ? store[int'(a)] : 16'h0000;
    endfunction

    // Memory model: acks after memDelay extra cycles, checks that the request
    // fields do not move while waiting, applies byte-enabled writes.
    always @(negedge MCLK) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else if (mem_req) begin
            if (waitCnt == 0) firstFields = {mem_addr, mem_we, mem_be, mem_wdata};
            else if (firstFields != {mem_addr, mem_we, mem_be, mem_wdata}) stableErr++;
            if (waitCnt >= memDelay) begin
                logic [15:0] w;
                mem_ack   = 1'b1;
                mem_rdata = readWord(mem_addr);
                txnLog.push_back({mem_addr, mem_we, mem_be, mem_wdata});
                if (mem_we) begin
                    w = readWord(mem_addr);
                    if (mem_be[0]) w[7:0]  = mem_wdata[7:0];
                    if (mem_be[1]) w[15:8] = mem_wdata[15:8];
                    store[int'(mem_addr)] = w;
                end
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // Counts loader handshakes at the edge where they take effect.
    always @(posedge MCLK) if (ld_ready) ldReadyCount++;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge MCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic cs, input logic oe,
                                 input logic lwr, input logic uwr, input logic [15:0] wd);
        cart_address = a;
        cart_cs      = cs;
        cart_oe      = oe;
        cart_lwr     = lwr;
        cart_uwr     = uwr;
        cart_data_wr = wd;
    endtask

    task automatic waitAck(input string tag, output int n);
        bit seen = 1'b0;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            if (mem_ack) begin
                seen = 1'b1;
                n = i;
                break;
            end
            tick();
        end
        checkOutput({tag, "AckSeen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int n, word, guard, bad, rd17;

        // Reset state
        tick();
        tick();
        checkOutput("resetOutputs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, cart_data,
                                     cart_data_en, ext_dtack, ld_ready}, 64'd0);
        SRES = 1'b1;
        tick();
        tick();

        // Loader: four word writes, cartridge read strobe is ignored meanwhile
        memDelay = 1;
        txnLog.delete();
        ldReadyCount = 0;
        ld_active = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = '0;
        ld_data   = 16'h1111;
        word  = 0;
        guard = 0;
        while (word < 4 && guard < 200) begin
            tick();
            guard++;
            if (guard == 3) applyStimulus(23'd7, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            if (ld_ready) begin
                word++;
                if (word < 4) begin
                    ld_addr = ADDR_W'(word);
                    ld_data = 16'(16'h1111 * (word + 1));
                end else begin
                    ld_valid = 1'b0;
                end
            end
        end
        checkOutput("ldWordsDone", 64'(word), 64'd4);
        repeat (3) tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        ld_active = 1'b0;
        tick();
        tick();
        checkOutput("ldTxnCount", 64'(txnLog.size()), 64'd4);
        checkOutput("ldReadyPulses", 64'(ldReadyCount), 64'd4);
        bad = 0;
        foreach (txnLog[i]) if (txnLog[i].we !== 1'b1 || txnLog[i].be !== 2'b11 ||
                                txnLog[i].addr !== ADDR_W'(i)) bad++;
        checkOutput("ldTxnFields", 64'(bad), 64'd0);
        checkOutput("ldMem0", 64'(readWord(23'd0)), 64'h1111);
        checkOutput("ldMem3", 64'(readWord(23'd3)), 64'h4444);

        // Read with 3-cycle ack delay
        store[2] = 16'hBEEF;
        memDelay = 3;
        txnLog.delete();
        applyStimulus(23'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("rdReqRise", {mem_req, ext_dtack}, 64'b10);
        waitAck("rd", n);
        checkOutput("rdAckDelay", 64'(n), 64'd3);
        checkOutput("rdNoDtackAtAck", {cart_data_en, ext_dtack}, 64'd0);
        tick();
        checkOutput("rdRespond", {mem_req, cart_data_en, ext_dtack, cart_data}, {3'b011, 16'hBEEF});
        tick();
        tick();
        checkOutput("rdDtackHeld", {cart_data_en, ext_dtack}, 64'b11);
        applyStimulus(23'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("rdRelease", {cart_data_en, ext_dtack, cart_data}, {2'b00, 16'hBEEF});
        checkOutput("rdTxn", {64'(txnLog.size()), txnLog[0].addr, txnLog[0].we, txnLog[0].be},
                    {64'd1, 23'd2, 1'b0, 2'b11});
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();

        // Low-byte write
        memDelay = 1;
        txnLog.delete();
        applyStimulus(23'h100000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A5);
        waitAck("wr", n);
        tick();
        checkOutput("wrDtack", {cart_data_en, ext_dtack}, 64'b01);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("wrRelease", {cart_data_en, ext_dtack}, 64'b00);
        checkOutput("wrTxn", {txnLog[0].addr, txnLog[0].we, txnLog[0].be, txnLog[0].wdata},
                    {23'h100000, 1'b1, 2'b01, 16'h00A5});
        checkOutput("wrMem", 64'(readWord(23'h100000)), 64'h00A5);

        // Strobe released before ack
        memDelay = 4;
        txnLog.delete();
        applyStimulus(23'd5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        waitAck("abort", n);
        tick();
        checkOutput("abortNoDtack", {cart_data_en, ext_dtack}, 64'b00);
        tick();
        checkOutput("abortIdle", {mem_req, ext_dtack, 64'(txnLog.size())}, {2'b00, 64'd1});

        // Reset asserted while waiting on a read
        memDelay = 6;
        applyStimulus(23'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("rstPreReq", 64'(mem_req), 64'd1);
        SRES = 1'b0;
        #1;
        checkOutput("rstOutputs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, cart_data,
                                   cart_data_en, ext_dtack, ld_ready}, 64'd0);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        SRES = 1'b1;
        tick();
        tick();

        // Zero-wait read after reset: dtack two cycles after the strobe
        memDelay = 0;
        applyStimulus(23'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("zwReqAck", {mem_req, mem_ack, ext_dtack}, 64'b110);
        tick();
        checkOutput("zwRespond", {cart_data_en, ext_dtack, cart_data}, {2'b11, 16'hBEEF});
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();

`ifdef CART_PREFETCH_EN
        // Read-ahead buffer: hit after a sequential read, miss after a write
        memDelay = 1;
        store[16] = 16'h1010;
        store[17] = 16'h1717;
        txnLog.delete();
        applyStimulus(23'h10, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitAck("pfFirst", n);
        tick();
        checkOutput("pfFirstData", 64'(cart_data), 64'h1010);
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (8) tick();
        checkOutput("pfIssued", {64'(txnLog.size()), txnLog[1].addr, txnLog[1].we}, {64'd2, 23'h11, 1'b0});
        applyStimulus(23'h11, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("pfHitNoReq", 64'(mem_req), 64'd0);
        tick();
        checkOutput("pfHitRespond", {cart_data_en, ext_dtack, cart_data}, {2'b11, 16'h1717});
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        checkOutput("pfHitNoMem", 64'(txnLog.size()), 64'd2);
        applyStimulus(23'h11, 1'b1, 1'b0, 1'b1, 1'b1, 16'h2222);
        waitAck("pfWr", n);
        tick();
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        applyStimulus(23'h11, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("pfMissReq", 64'(mem_req), 64'd1);
        waitAck("pfMiss", n);
        tick();
        checkOutput("pfMissRespond", {ext_dtack, cart_data}, {1'b1, 16'h2222});
        applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) tick();
        rd17 = 0;
        foreach (txnLog[i]) if (txnLog[i].addr == 23'h11 && txnLog[i].we == 1'b0) rd17++;
        checkOutput("pfMemReads11", 64'(rd17), 64'd2);
`endif

        checkOutput("fieldsStable", 64'(stableErr), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cart_mem_ctrl.md
# cart_mem_ctrl

Sequencer that shares one external 16-bit word memory between the cartridge bus of the board and a ROM loader. It watches the cartridge strobes (`cart_cs`, `cart_oe`, `cart_lwr`, `cart_uwr`, `cart_address`) and turns each access into a single memory transaction. It then returns `cart_data`/`cart_data_en` and an `ext_dtack` acknowledge to the board. While the loader is active it owns the memory exclusively and cartridge accesses are ignored.

## Interface
- `ADDR_W`, 23: word-address width on both the cartridge side and the memory side.
- `MCLK` in 1: system clock; the board master clock, same domain as all cart signals.
- `SRES` in 1: reset, asynchronous, active-low.
- `cart_address` in ADDR_W: cartridge word address.
- `cart_cs` in 1: cartridge chip select, active-high.
- `cart_oe` in 1: read strobe, active-high.
- `cart_lwr`, `cart_uwr` in 1 each: low/high byte write strobes, active-high.
- `cart_data_wr` in 16: write data.
- `cart_data` out 16: read data to the board.
- `cart_data_en` out 1: read data is driving the bus.
- `ext_dtack` out 1: acknowledge; high = transfer complete.
- `ld_active` in 1: loader owns memory; the cartridge is held idle.
- `ld_valid` in 1, `ld_ready` out 1: loader write handshake.
- `ld_addr` in ADDR_W, `ld_data` in 16: loader word write (both bytes).
- `mem_req` out 1: memory request, held until ack.
- `mem_ack` in 1: one-cycle completion.
- `mem_we` out 1, `mem_be` out 2 ({hi,lo}), `mem_addr` out ADDR_W, `mem_wdata` out 16.
- `mem_rdata` in 16: valid in the `mem_ack` cycle.

## Operation
- Strobes are registered each cycle. A read starts on the rising edge of `cart_cs & cart_oe`. A write starts on the rising edge of `cart_cs & (cart_lwr | cart_uwr)`.
- State machine:
  - IDLE → RD_WAIT, WR_WAIT, LD_WAIT or PF_WAIT (PF only with the macro).
  - RD_WAIT / WR_WAIT → HOLD on `mem_ack`.
  - LD_WAIT → IDLE on `mem_ack`.
  - HOLD → IDLE once the strobe that started the access is released.
- Priority in IDLE:
  1. `ld_active & ld_valid` (cartridge edges are discarded while `ld_active`).
  2. Cartridge read.
  3. Cartridge write.
  4. Pending prefetch.
- If the read and write edges arrive in the same cycle, the read is serviced and the write edge is dropped.
- Transaction fields:
  - Read: `mem_we`=0, `mem_be`=2'b11.
  - Write: `mem_be`={`cart_uwr`,`cart_lwr`} sampled at the edge, `mem_wdata`=`cart_data_wr`.
  - Loader: `mem_be`=2'b11; `ld_ready` pulses high for one cycle in the `mem_ack` cycle.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are latched when `mem_req` rises and stay stable until `mem_ack`.
- Read data is latched into `cart_data` on `mem_ack`. `cart_data` keeps its last value when not enabled.
- A strobe released before `mem_ack`:
  - the transaction still completes;
  - `cart_data_en` and `ext_dtack` are not asserted;
  - the FSM returns to IDLE.
- `ld_active` falling mid-transaction: the current loader write completes, then cartridge service resumes.

## Timing
- Reset values: all outputs 0, FSM in IDLE, prefetch buffer invalid. Asserting reset mid-transaction drops `mem_req` immediately; the memory must tolerate an abandoned request.
- Strobe rises at cycle N: edge detected at N+1, `mem_req` high at N+1, held through the `mem_ack` cycle and low the cycle after.
- Read: `cart_data_en` and `ext_dtack` high the cycle after `mem_ack`, held until the strobe falls, low the cycle after that.
- Write: `ext_dtack` follows the same rule as a read; `cart_data_en` stays 0.
- Zero-wait memory (`mem_ack` in the `mem_req` cycle) gives read latency of 2 cycles from strobe to `ext_dtack`.
- Back-to-back accesses: a new edge is only recognised from IDLE; the strobe must drop for at least 1 cycle between accesses.
- Address arithmetic wraps modulo 2^ADDR_W.

## Configuration
- `CART_PREFETCH_EN` defined:
  - After every completed cartridge read of address A, the FSM issues a read of A+1 into a one-word buffer (`pf_addr`, `pf_data`, `pf_valid`).
  - A read edge hitting a valid `pf_addr` skips memory; `cart_data_en`/`ext_dtack` are high at N+2.
  - A read edge arriving during PF_WAIT waits for the prefetch to complete, then is re-evaluated for a hit.
  - A cartridge write to `pf_addr` invalidates the buffer; any loader write or `ld_active` high invalidates it.
- Not defined: no buffer and no PF_WAIT state; every read goes to memory.

## Test plan
- Loader: `ld_active`=1, 4 writes to 0x000000–0x000003 with data 0x1111..0x4444 → 4 `mem_we`=1, `mem_be`=11 transactions, 4 `ld_ready` pulses; a cartridge read strobe during this produces no `mem_req`.
- Read with 3-cycle `mem_ack` delay, addr 0x000002 returns 0xBEEF → `cart_data`=0xBEEF, `cart_data_en`=`ext_dtack`=1 from ack+1 until the cycle after `cart_oe` falls.
- Byte write, `cart_lwr` only, addr 0x100000, data 0x00A5 → `mem_be`=01, `mem_wdata`=0x00A5, `ext_dtack` pulse, `cart_data_en` stays 0.
- Strobe released before ack, and `SRES` low mid-RD_WAIT → first case: no `ext_dtack`, return to IDLE; second case: all outputs 0 immediately, next read serviced normally.
- `CART_PREFETCH_EN` build: reads of 0x10 then 0x11 → a single memory read for 0x11 (issued as prefetch), second access acked at N+2. Repeating after a write to 0x11 → the buffer misses and memory is read again.
